// File: rtl/debounce_edge.sv
// Debounce a raw asynchronous input into a clean level plus one-cycle rise/fall strobes.
// Latency: STABLE_COUNT+3 clock edges from the first sample of a new level (2 sync + entry + count).
// Backpressure: none; the input is sampled every cycle and the outputs are strobes/levels.
module debounce_edge #(
   parameter int STABLE_COUNT = 10,
   parameter int CNT_WIDTH    = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic bounce_in,
   output logic db_out,
   output logic db_bar,
   output logic rise_pulse,
   output logic fall_pulse
);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   // Count value at which a WAIT state accepts the new level.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

   logic                 sync_1;
   logic                 sync_2;
   state_t               state;
   state_t               state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic                 db_nxt;
   logic                 rise_nxt;
   logic                 fall_nxt;

   // Two-flop synchroniser; only sync_2 is allowed to reach the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= bounce_in;
         sync_2 <= sync_1;
      end
   end

   // State, stability counter and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE_LOW;
         cnt        <= '0;
         db_out     <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         db_out     <= db_nxt;
         rise_pulse <= rise_nxt;
         fall_pulse <= fall_nxt;
      end
   end

   // Next-state logic: a WAIT state needs STABLE_COUNT further agreeing samples
   // after entry; any disagreeing sample drops back to IDLE and discards the count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      db_nxt    = db_out;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         IDLE_LOW: begin
            if (sync_2) begin
               state_nxt = WAIT_HIGH;
               cnt_nxt   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!sync_2) begin
               state_nxt = IDLE_LOW;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_HIGH;
               db_nxt    = 1'b1;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         IDLE_HIGH: begin
            if (!sync_2) begin
               state_nxt = WAIT_LOW;
               cnt_nxt   = '0;
            end
         end
         WAIT_LOW: begin
            if (sync_2) begin
               state_nxt = IDLE_HIGH;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE_LOW;
               db_nxt    = 1'b0;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign db_bar = ~db_out;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: three parameterisations share one stimulus stream.
// Outputs are checked every cycle against a run-length model, plus literal timing checks.
// The stimulus drives inputs in the low clock phase and samples 2 time units after each rising edge.
module tb_debounce_edge;

   logic       clk = 1'b0;
   logic       reset;
   logic       bounce_in;
   logic [2:0] db_out;
   logic [2:0] db_bar;
   logic [2:0] rise_pulse;
   logic [2:0] fall_pulse;

   always #5 clk = ~clk;

   debounce_edge u_dut0 (
      .clk(clk), .reset(reset), .bounce_in(bounce_in),
      .db_out(db_out[0]), .db_bar(db_bar[0]),
      .rise_pulse(rise_pulse[0]), .fall_pulse(fall_pulse[0])
   );

   debounce_edge #(.STABLE_COUNT(1), .CNT_WIDTH(1)) u_dut1 (
      .clk(clk), .reset(reset), .bounce_in(bounce_in),
      .db_out(db_out[1]), .db_bar(db_bar[1]),
      .rise_pulse(rise_pulse[1]), .fall_pulse(fall_pulse[1])
   );

   debounce_edge #(.STABLE_COUNT(16), .CNT_WIDTH(4)) u_dut2 (
      .clk(clk), .reset(reset), .bounce_in(bounce_in),
      .db_out(db_out[2]), .db_bar(db_bar[2]),
      .rise_pulse(rise_pulse[2]), .fall_pulse(fall_pulse[2])
   );

   int checks = 0;
   int errors = 0;
   int sc [3] = '{10, 1, 16};

   // Model: the input is seen by the debouncer two edges after it is sampled;
   // a level is accepted once it has disagreed with the output for sc+1 edges in a row.
   bit m_d1, m_d2;
   bit m_db   [3];
   bit m_rise [3];
   bit m_fall [3];
   int m_run  [3];

   bit prev_rise [3];
   bit prev_fall [3];
   int n_rise     [3];
   int n_fall     [3];
   int first_rise [3];
   int first_fall [3];
   int step_n;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_d1 = 1'b0;
      m_d2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_db[i]      = 1'b0;
         m_rise[i]    = 1'b0;
         m_fall[i]    = 1'b0;
         m_run[i]     = 0;
         prev_rise[i] = 1'b0;
         prev_fall[i] = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit v;
      v    = m_d2;
      m_d2 = m_d1;
      m_d1 = bounce_in;
      for (int i = 0; i < 3; i++) begin
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         if (v != m_db[i]) begin
            m_run[i]++;
            if (m_run[i] == sc[i] + 1) begin
               m_db[i]   = v;
               m_rise[i] = v;
               m_fall[i] = !v;
               m_run[i]  = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("db_out[%0d]", i), int'(db_out[i]), int'(m_db[i]));
         check($sformatf("db_bar[%0d]", i), int'(db_bar[i]), int'(!db_out[i]));
         check($sformatf("rise_pulse[%0d]", i), int'(rise_pulse[i]), int'(m_rise[i]));
         check($sformatf("fall_pulse[%0d]", i), int'(fall_pulse[i]), int'(m_fall[i]));
         check($sformatf("strobe_overlap[%0d]", i), int'(rise_pulse[i] & fall_pulse[i]), 0);
         check($sformatf("rise_long[%0d]", i), int'(rise_pulse[i] & prev_rise[i]), 0);
         check($sformatf("fall_long[%0d]", i), int'(fall_pulse[i] & prev_fall[i]), 0);
         prev_rise[i] = rise_pulse[i];
         prev_fall[i] = fall_pulse[i];
         if (rise_pulse[i] === 1'b1) begin
            n_rise[i]++;
            if (first_rise[i] == 0) first_rise[i] = step_n;
         end
         if (fall_pulse[i] === 1'b1) begin
            n_fall[i]++;
            if (first_fall[i] == 0) first_fall[i] = step_n;
         end
      end
   endtask

   task automatic clear_stats();
      step_n = 0;
      for (int i = 0; i < 3; i++) begin
         n_rise[i]     = 0;
         n_fall[i]     = 0;
         first_rise[i] = 0;
         first_fall[i] = 0;
      end
   endtask

   // Called in the low clock phase; drives one sample and checks after the edge.
   task automatic step(input logic b);
      bounce_in = b;
      @(posedge clk);
      if (reset) model_edge();
      #2;
      step_n++;
      compare_all();
      @(negedge clk);
   endtask

   task automatic run(input logic b, input int n);
      for (int k = 0; k < n; k++) step(b);
   endtask

   task automatic assert_reset();
      reset = 1'b0;
      #1;
      model_reset();
      compare_all();
   endtask

   initial begin
      reset     = 1'b0;
      bounce_in = 1'b1;
      model_reset();
      clear_stats();
      @(negedge clk);
      #1;
      compare_all();
      check("reset_db_out", int'(db_out[0]), 0);
      check("reset_db_bar", int'(db_bar[0]), 1);
      run(1'b1, 3);

      // Release with the input already high: acceptance on the 13th edge.
      reset = 1'b1;
      clear_stats();
      run(1'b1, 25);
      check("rel_rise_edge_sc10", first_rise[0], 13);
      check("rel_rise_edge_sc1", first_rise[1], 4);
      check("rel_rise_edge_sc16", first_rise[2], 19);
      check("rel_rise_count_sc10", n_rise[0], 1);
      run(1'b0, 25);

      // Threshold: 10 cycles rejected, 11 accepted.
      clear_stats();
      run(1'b1, 10);
      run(1'b0, 25);
      check("w10_rise_count_sc10", n_rise[0], 0);
      check("w10_rise_count_sc16", n_rise[2], 0);
      check("w10_rise_count_sc1", n_rise[1], 1);
      clear_stats();
      run(1'b1, 11);
      run(1'b0, 20);
      check("w11_rise_edge_sc10", first_rise[0], 13);
      check("w11_rise_count_sc10", n_rise[0], 1);
      check("w11_fall_edge_sc10", first_fall[0], 24);
      check("w11_fall_count_sc10", n_fall[0], 1);
      check("w11_rise_count_sc16", n_rise[2], 0);
      run(1'b0, 5);

      // Bounce train then a stable run that starts on step 6.
      clear_stats();
      step(1'b1); step(1'b0); step(1'b1); step(1'b1); step(1'b0); step(1'b1);
      run(1'b1, 15);
      check("train_rise_count_sc10", n_rise[0], 1);
      check("train_rise_edge_sc10", first_rise[0], 18);
      run(1'b0, 25);

      // Reset mid-count, then a full-length acceptance after release.
      clear_stats();
      run(1'b1, 7);
      assert_reset();
      run(1'b1, 3);
      check("midrst_db_out_sc10", int'(db_out[0]), 0);
      check("midrst_rise_count_sc10", n_rise[0], 0);
      reset = 1'b1;
      clear_stats();
      run(1'b1, 20);
      check("midrst_rise_edge_sc10", first_rise[0], 13);
      check("midrst_rise_count_after", n_rise[0], 1);
      run(1'b0, 25);

      // STABLE_COUNT=1 boundary: 1 cycle rejected, 2 cycles accepted at E3.
      clear_stats();
      run(1'b1, 1);
      run(1'b0, 5);
      check("sc1_w1_rise_count", n_rise[1], 0);
      clear_stats();
      run(1'b1, 2);
      run(1'b0, 5);
      check("sc1_w2_rise_edge", first_rise[1], 4);
      check("sc1_w2_rise_count", n_rise[1], 1);
      run(1'b0, 5);

      // STABLE_COUNT=16 boundary: 16 cycles rejected, 17 accepted.
      clear_stats();
      run(1'b1, 16);
      run(1'b0, 25);
      check("sc16_w16_rise_count", n_rise[2], 0);
      clear_stats();
      run(1'b1, 17);
      run(1'b0, 5);
      check("sc16_w17_rise_edge", first_rise[2], 19);
      check("sc16_w17_rise_count", n_rise[2], 1);
      run(1'b0, 25);
      check("sc16_w17_fall_count", n_fall[2], 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
